stepper_ramp_ctrl: RTL and testbench

Converts the run/direction commands from the track-balancing state machine (enable, direct) into stepper-driver signals: step pulses, direction and driver enable.

---
 rtl/stepper_pkg.sv | 23 ++
 rtl/step_timer.sv | 52 +++++
 rtl/stepper_ramp_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_stepper_ramp_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper ramp controller.
//   state_t   : one-hot controller state (5 bits)
//   DIV_W_DEF : default width of the period/divider registers
//   POS_W     : width of the signed step position counter
//   is_motion : true in the states that emit step pulses
package stepper_pkg;

    localparam int DIV_W_DEF = 24;
    localparam int POS_W     = 16;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_SETUP  = 5'b00010,
        ST_ACCEL  = 5'b00100,
        ST_CRUISE = 5'b01000,
        ST_DECEL  = 5'b10000
    } state_t;

    function automatic logic is_motion(input state_t s);
        return (s == ST_ACCEL) || (s == ST_CRUISE) || (s == ST_DECEL);
    endfunction

endpackage

// File: rtl/step_timer.sv
// Step period counter and step pulse generator.
//   sclk, s_rst_n : clock, asynchronous active-low reset
//   cur_div       : current step period in sclk cycles
//   run           : keep counting into the next cycle (motion continues)
//   restart       : begin a fresh period at count 0 (first step of a move)
//   period_end    : counter is on the last cycle of the current period
//   step_rise     : step goes high at the coming clock edge
//   step          : registered step pulse, high for the first PULSE_W cycles
module step_timer #(
    parameter int DIV_W   = 24,
    parameter int PULSE_W = 100
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic [DIV_W-1:0] cur_div,
    input  logic             run,
    input  logic             restart,
    output logic             period_end,
    output logic             step_rise,
    output logic             step
);

    logic [DIV_W-1:0] per_reg;
    logic [DIV_W-1:0] per_next;
    logic             step_reg;
    logic             step_next;

    assign period_end = (per_reg == cur_div - 1'b1);
    assign step_rise  = restart || (run && period_end);
    assign step       = step_reg;

    // The step level is derived from the counter value that becomes current
    // at the edge, so step and the counter always stay aligned.
    always_comb begin
        per_next = '0;
        if (!restart && run && !period_end) begin
            per_next = per_reg + 1'b1;
        end
        step_next = (restart || run) && (per_next < DIV_W'(PULSE_W));
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            per_reg  <= '0;
            step_reg <= 1'b0;
        end else begin
            per_reg  <= per_next;
            step_reg <= step_next;
        end
    end

endmodule

// File: rtl/stepper_ramp_ctrl.sv
// Trapezoidal-ramp stepper controller between the balancing state machine
// and an external step/dir driver. A move never reverses or stops at speed:
// it decelerates to the start period, then re-enters the direction dwell.
//   sclk, s_rst_n : clock, asynchronous active-low reset
//   enable        : run request
//   direct        : requested direction (1 = clockwise)
//   step, dir     : driver step pulse and direction
//   drv_en_n      : driver enable, active low (held in every non-idle state)
//   busy          : controller not idle
//   at_speed      : cruising at DIV_MIN
//   pos           : signed, wrapping step position
// Optional build macro LIMIT_STOP_EN adds lim_l_n / lim_r_n (active-low end
// switches) and a sticky fault output; a hit aborts straight to idle and the
// block stays idle until enable has been seen low.
module stepper_ramp_ctrl
    import stepper_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEF,
    parameter int DIV_MAX   = 200_000,
    parameter int DIV_MIN   = 50_000,
    parameter int DIV_STEP  = 5_000,
    parameter int PULSE_W   = 100,
    parameter int DIR_SETUP = 1_000
) (
    input  logic                    sclk,
    input  logic                    s_rst_n,
    input  logic                    enable,
    input  logic                    direct,
`ifdef LIMIT_STOP_EN
    input  logic                    lim_l_n,
    input  logic                    lim_r_n,
    output logic                    fault,
`endif
    output logic                    step,
    output logic                    dir,
    output logic                    drv_en_n,
    output logic                    busy,
    output logic                    at_speed,
    output logic signed [POS_W-1:0] pos
);

    localparam logic [DIV_W-1:0] MAX_DIV    = DIV_W'(DIV_MAX);
    localparam logic [DIV_W-1:0] MIN_DIV    = DIV_W'(DIV_MIN);
    localparam logic [DIV_W:0]   STEP_X     = (DIV_W + 1)'(DIV_STEP);
    localparam int               DWELL_W    = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DIR_SETUP - 1);

    state_t                   state_reg, state_next;
    logic [DIV_W-1:0]         cur_div_reg, cur_div_next;
    logic [DWELL_W-1:0]       dwell_reg, dwell_next;
    logic                     dir_reg, dir_next;
    logic signed [POS_W-1:0]  pos_reg, pos_next;
    logic                     busy_reg, busy_next;
    logic                     at_speed_reg, at_speed_next;
    logic                     drv_en_n_reg, drv_en_n_next;

    logic                     run, restart, period_end, step_rise;
    logic                     stop_req, start_ok;
    logic [DIV_W:0]           div_sum, div_diff;
    logic [DIV_W-1:0]         div_up;
    logic                     at_floor;

    // Ramp arithmetic is one bit wider than the divider so neither the
    // increment nor the decrement can wrap before saturation.
    assign div_sum  = {1'b0, cur_div_reg} + STEP_X;
    assign div_diff = {1'b0, cur_div_reg} - STEP_X;
    assign div_up   = (div_sum >= {1'b0, MAX_DIV}) ? MAX_DIV : div_sum[DIV_W-1:0];
    assign at_floor = div_diff[DIV_W] || (div_diff[DIV_W-1:0] <= MIN_DIV);

    assign stop_req = !enable || (direct != dir_reg);

`ifdef LIMIT_STOP_EN
    logic fault_reg, fault_next, lim_hit;
    // Only the switch on the side we are travelling towards matters.
    assign lim_hit  = (state_reg != ST_IDLE) && (dir_reg ? !lim_r_n : !lim_l_n);
    assign start_ok = enable && !fault_reg;
    assign fault    = fault_reg;
`else
    assign start_ok = enable;
`endif

    step_timer #(
        .DIV_W   (DIV_W),
        .PULSE_W (PULSE_W)
    ) u_timer (
        .sclk       (sclk),
        .s_rst_n    (s_rst_n),
        .cur_div    (cur_div_reg),
        .run        (run),
        .restart    (restart),
        .period_end (period_end),
        .step_rise  (step_rise),
        .step       (step)
    );

    // State register (plus the datapath registers it owns).
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_reg    <= ST_IDLE;
            cur_div_reg  <= MAX_DIV;
            dwell_reg    <= '0;
            dir_reg      <= 1'b0;
            pos_reg      <= '0;
            busy_reg     <= 1'b0;
            at_speed_reg <= 1'b0;
            drv_en_n_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cur_div_reg  <= cur_div_next;
            dwell_reg    <= dwell_next;
            dir_reg      <= dir_next;
            pos_reg      <= pos_next;
            busy_reg     <= busy_next;
            at_speed_reg <= at_speed_next;
            drv_en_n_reg <= drv_en_n_next;
        end
    end

`ifdef LIMIT_STOP_EN
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= fault_next;
        end
    end
`endif

    // Next-state and ramp logic. Motion states only act at period end so a
    // pulse or period is never cut short.
    always_comb begin
        state_next   = state_reg;
        cur_div_next = cur_div_reg;
        dwell_next   = dwell_reg;
        dir_next     = dir_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next   = ST_SETUP;
                    dir_next     = direct;
                    cur_div_next = MAX_DIV;
                    dwell_next   = '0;
                end
            end
            ST_SETUP: begin
                if (dwell_reg == DWELL_LAST) begin
                    state_next = ST_ACCEL;
                end else begin
                    dwell_next = dwell_reg + 1'b1;
                end
            end
            ST_ACCEL: begin
                if (period_end) begin
                    if (stop_req) begin
                        state_next   = ST_DECEL;
                        cur_div_next = div_up;
                    end else if (at_floor) begin
                        state_next   = ST_CRUISE;
                        cur_div_next = MIN_DIV;
                    end else begin
                        cur_div_next = div_diff[DIV_W-1:0];
                    end
                end
            end
            ST_CRUISE: begin
                if (period_end && stop_req) begin
                    state_next   = ST_DECEL;
                    cur_div_next = div_up;
                end
            end
            ST_DECEL: begin
                // Deceleration always runs to completion, even if the stop
                // request has gone away in the meantime.
                if (period_end) begin
                    if (cur_div_reg == MAX_DIV) begin
                        if (enable) begin
                            state_next = ST_SETUP;
                            dir_next   = direct;
                            dwell_next = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        cur_div_next = div_up;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
`ifdef LIMIT_STOP_EN
        if (lim_hit) begin
            state_next = ST_IDLE;
        end
`endif
    end

`ifdef LIMIT_STOP_EN
    always_comb begin
        fault_next = fault_reg;
        if (lim_hit) begin
            fault_next = 1'b1;
        end else if ((state_reg == ST_IDLE) && !enable) begin
            fault_next = 1'b0;
        end
    end
`endif

    // Timer control: keep counting while motion continues, start a fresh
    // period when leaving the direction dwell. Anything else clears it.
    assign run     = is_motion(state_reg) && is_motion(state_next);
    assign restart = (state_reg == ST_SETUP) && (state_next == ST_ACCEL);

    // Output decode from the upcoming state so every output is a register.
    always_comb begin
        busy_next     = (state_next != ST_IDLE);
        at_speed_next = (state_next == ST_CRUISE);
        drv_en_n_next = (state_next == ST_IDLE);
        pos_next      = pos_reg;
        if (step_rise) begin
            pos_next = dir_reg ? (pos_reg + POS_W'(1)) : (pos_reg - POS_W'(1));
        end
    end

    assign dir      = dir_reg;
    assign drv_en_n = drv_en_n_reg;
    assign busy     = busy_reg;
    assign at_speed = at_speed_reg;
    assign pos      = pos_reg;

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Testbench for stepper_ramp_ctrl: behavioural model compared every cycle,
// directed ramp scenarios with literal period checks, then random commands.
module tb_stepper_ramp_ctrl;

    localparam int DIV_MAX   = 20;
    localparam int DIV_MIN   = 8;
    localparam int DIV_STEP  = 4;
    localparam int PULSE_W   = 2;
    localparam int DIR_SETUP = 5;

    localparam int M_IDLE   = 0;
    localparam int M_SETUP  = 1;
    localparam int M_ACCEL  = 2;
    localparam int M_CRUISE = 3;
    localparam int M_DECEL  = 4;

    typedef struct {
        int      mode;
        int      cnt;
        int      div;
        shortint pos;
        bit      dir;
        bit      fault;
    } mstate_t;

    logic               sclk = 1'b0;
    logic               s_rst_n = 1'b0;
    logic               enable = 1'b0;
    logic               direct = 1'b0;
    logic               step, dir, drv_en_n, busy, at_speed;
    logic signed [15:0] pos;
`ifdef LIMIT_STOP_EN
    logic               lim_l_n = 1'b1;
    logic               lim_r_n = 1'b1;
    logic               fault;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    stepper_ramp_ctrl #(
        .DIV_W     (24),
        .DIV_MAX   (DIV_MAX),
        .DIV_MIN   (DIV_MIN),
        .DIV_STEP  (DIV_STEP),
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP)
    ) dut (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .enable   (enable),
        .direct   (direct),
`ifdef LIMIT_STOP_EN
        .lim_l_n  (lim_l_n),
        .lim_r_n  (lim_r_n),
        .fault    (fault),
`endif
        .step     (step),
        .dir      (dir),
        .drv_en_n (drv_en_n),
        .busy     (busy),
        .at_speed (at_speed),
        .pos      (pos)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic mstate_t model_reset();
        mstate_t r;
        r.mode = M_IDLE; r.cnt = 0; r.div = DIV_MAX; r.pos = 0; r.dir = 1'b0; r.fault = 1'b0;
        return r;
    endfunction

    function automatic int ramp_up(input int d);
        return (d + DIV_STEP > DIV_MAX) ? DIV_MAX : d + DIV_STEP;
    endfunction

    // One clock of the controller described by its rules: a move is a list
    // of whole periods; the period length only changes at a period boundary.
    function automatic mstate_t model_next(input mstate_t s, input bit en, input bit dr,
                                           input bit ll, input bit lr);
        mstate_t n;
        bit stop;
        n = s;
        stop = !en || (dr != s.dir);
        if (s.mode != M_IDLE && (s.dir ? !lr : !ll)) begin
            n.mode = M_IDLE; n.cnt = 0; n.fault = 1'b1;
            return n;
        end
        case (s.mode)
            M_IDLE: begin
                if (en && !s.fault) begin
                    n.mode = M_SETUP; n.cnt = 0; n.dir = dr; n.div = DIV_MAX;
                end
                if (!en) n.fault = 1'b0;
            end
            M_SETUP: begin
                if (s.cnt == DIR_SETUP - 1) begin
                    n.mode = M_ACCEL; n.cnt = 0;
                    n.pos = s.dir ? s.pos + 16'sd1 : s.pos - 16'sd1;
                end else begin
                    n.cnt = s.cnt + 1;
                end
            end
            default: begin
                if (s.cnt != s.div - 1) begin
                    n.cnt = s.cnt + 1;
                end else begin
                    n.cnt = 0;
                    if (s.mode == M_ACCEL) begin
                        if (stop) begin
                            n.mode = M_DECEL; n.div = ramp_up(s.div);
                        end else if (s.div - DIV_STEP <= DIV_MIN) begin
                            n.mode = M_CRUISE; n.div = DIV_MIN;
                        end else begin
                            n.div = s.div - DIV_STEP;
                        end
                    end else if (s.mode == M_CRUISE) begin
                        if (stop) begin
                            n.mode = M_DECEL; n.div = ramp_up(s.div);
                        end
                    end else begin
                        if (s.div == DIV_MAX) begin
                            if (en) begin
                                n.mode = M_SETUP; n.dir = dr; n.div = DIV_MAX;
                            end else begin
                                n.mode = M_IDLE;
                            end
                        end else begin
                            n.div = ramp_up(s.div);
                        end
                    end
                    if (n.mode >= M_ACCEL) begin
                        n.pos = s.dir ? s.pos + 16'sd1 : s.pos - 16'sd1;
                    end
                end
            end
        endcase
        return n;
    endfunction

    mstate_t m = '{mode: M_IDLE, cnt: 0, div: DIV_MAX, pos: 16'sd0, dir: 1'b0, fault: 1'b0};

    always @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            m <= model_reset();
        end else begin
`ifdef LIMIT_STOP_EN
            m <= model_next(m, enable, direct, lim_l_n, lim_r_n);
`else
            m <= model_next(m, enable, direct, 1'b1, 1'b1);
`endif
            cyc <= cyc + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge sclk) begin
        check("step", int'(step), int'(m.mode >= M_ACCEL && m.cnt < PULSE_W));
        check("dir", int'(dir), int'(m.dir));
        check("drv_en_n", int'(drv_en_n), int'(m.mode == M_IDLE));
        check("busy", int'(busy), int'(m.mode != M_IDLE));
        check("at_speed", int'(at_speed), int'(m.mode == M_CRUISE));
        check("pos", int'(pos), int'(m.pos));
`ifdef LIMIT_STOP_EN
        check("fault", int'(fault), int'(m.fault));
`endif
    end

    // Event monitor used by the literal timing checks.
    int  rise_q[$];
    logic step_q = 1'b0, busy_q = 1'b0, at_q = 1'b0;
    int  busy_rise = 0, busy_fall = 0, at_rise = 0;

    always @(negedge sclk) begin
        if (step && !step_q) rise_q.push_back(cyc);
        if (busy && !busy_q) busy_rise <= cyc;
        if (!busy && busy_q) busy_fall <= cyc;
        if (at_speed && !at_q) at_rise <= cyc;
        step_q <= step;
        busy_q <= busy;
        at_q   <= at_speed;
    end

    function automatic bit cond(input int which, input int arg);
        case (which)
            0:       return busy == 1'b0;
            1:       return at_speed == 1'b1;
            2:       return rise_q.size() >= arg;
            default: return int'(dir) == arg;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sclk);
            #1;
        end
    endtask

    task automatic wait_for(input int which, input int arg, input int budget, input string what);
        int k;
        k = 0;
        while (!cond(which, arg) && k < budget) begin
            tick(1);
            k++;
        end
        check(what, int'(cond(which, arg)), 1);
    endtask

    initial begin
        int n;
        int k;
        int setup_cyc;
        int exp_iv[5];
        exp_iv[0] = 20; exp_iv[1] = 16; exp_iv[2] = 12; exp_iv[3] = 8; exp_iv[4] = 8;

        tick(3);
        s_rst_n = 1'b1;
        tick(2);

        // Start from idle: dir/driver enable next cycle, 5-cycle dwell, ramp.
        rise_q.delete();
        enable = 1'b1; direct = 1'b1;
        tick(1);
        check("start_dir", int'(dir), 1);
        check("start_drv_en_n", int'(drv_en_n), 0);
        wait_for(2, 6, 200, "wait_six_steps");
        check("first_step_delay", rise_q[0] - busy_rise, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("accel_period_%0d", i), rise_q[i+1] - rise_q[i], exp_iv[i]);
        end
        check("at_speed_on_4th", at_rise, rise_q[3]);

        // Stop from cruise.
        tick($urandom_range(0, 7));
        enable = 1'b0;
        wait_for(0, 0, 200, "wait_stop_idle");
        n = rise_q.size();
        check("stop_last8", rise_q[n-3] - rise_q[n-4], 8);
        check("stop_p12", rise_q[n-2] - rise_q[n-3], 12);
        check("stop_p16", rise_q[n-1] - rise_q[n-2], 16);
        check("stop_p20", busy_fall - rise_q[n-1], 20);
        check("stop_pos", int'(pos), n);

        // Reversal in cruise.
        rise_q.delete();
        enable = 1'b1; direct = 1'b1;
        wait_for(1, 0, 200, "wait_cruise_fwd");
        tick($urandom_range(0, 7));
        direct = 1'b0;
        wait_for(3, 0, 200, "wait_dir_flip");
        setup_cyc = cyc;
        wait_for(1, 0, 200, "wait_cruise_rev");
        k = 0;
        while (k < rise_q.size() && rise_q[k] <= setup_cyc) k++;
        check("rev_index_ok", int'(k >= 1 && k + 3 < rise_q.size()), 1);
        check("rev_last20", setup_cyc - rise_q[k-1], 20);
        check("rev_dwell", rise_q[k] - setup_cyc, 5);
        check("rev_p20", rise_q[k+1] - rise_q[k], 20);
        check("rev_p16", rise_q[k+2] - rise_q[k+1], 16);
        check("rev_p12", rise_q[k+3] - rise_q[k+2], 12);
        enable = 1'b0;
        wait_for(0, 0, 300, "wait_rev_idle");

        // Stop during the 16-cycle accel period.
        rise_q.delete();
        direct = 1'($urandom_range(0, 1));
        enable = 1'b1;
        wait_for(2, 2, 100, "wait_accel16");
        tick($urandom_range(0, 12));
        enable = 1'b0;
        wait_for(0, 0, 200, "wait_accel_stop_idle");
        check("accel_stop_steps", rise_q.size(), 3);
        check("accel_stop_p16", rise_q[2] - rise_q[1], 16);
        check("accel_stop_p20", busy_fall - rise_q[2], 20);

        // Asynchronous reset while step is high.
        rise_q.delete();
        direct = 1'($urandom_range(0, 1));
        enable = 1'b1;
        wait_for(2, 2, 100, "wait_step_high");
        check("rst_pre_step", int'(step), 1);
        s_rst_n = 1'b0;
        #1;
        check("rst_step", int'(step), 0);
        check("rst_pos", int'(pos), 0);
        check("rst_drv_en_n", int'(drv_en_n), 1);
        check("rst_busy", int'(busy), 0);
        enable = 1'b0;
        tick(2);
        s_rst_n = 1'b1;
        tick(10);
        check("post_rst_idle", int'(busy), 0);
        enable = 1'b1;
        tick(1);
        check("post_rst_start", int'(busy), 1);
        enable = 1'b0;
        wait_for(0, 0, 300, "wait_post_rst_idle");

`ifdef LIMIT_STOP_EN
        // End switch hit while cruising clockwise.
        enable = 1'b1; direct = 1'b1;
        wait_for(1, 0, 200, "wait_cruise_lim");
        lim_r_n = 1'b0;
        tick(1);
        check("lim_idle", int'(busy), 0);
        check("lim_fault", int'(fault), 1);
        lim_r_n = 1'b1;
        tick(10);
        check("lim_hold_idle", int'(busy), 0);
        enable = 1'b0;
        tick(1);
        check("lim_fault_clear", int'(fault), 0);
        enable = 1'b1;
        tick(1);
        check("lim_restart", int'(busy), 1);
        enable = 1'b0;
        wait_for(0, 0, 300, "wait_lim_idle");
`endif

        // Random command sequence checked by the per-cycle model.
        for (int i = 0; i < 40; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            direct = 1'($urandom_range(0, 1));
`ifdef LIMIT_STOP_EN
            lim_l_n = ($urandom_range(0, 15) != 0);
            lim_r_n = ($urandom_range(0, 15) != 0);
`endif
            tick($urandom_range(1, 80));
        end
`ifdef LIMIT_STOP_EN
        lim_l_n = 1'b1; lim_r_n = 1'b1;
`endif
        enable = 1'b0;
        wait_for(0, 0, 300, "wait_final_idle");
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
